// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_basic transmitter among NUM_REQ byte-stream
// requesters. Round-robin arbitration is done per packet: the winner keeps the
// UART until one of its bytes is flagged last.
// Optional feature macro: UART_ARB_TIMEOUT_EN. When it is defined, a stalled
// owner loses its grant after TIMEOUT_CYCLES idle clocks and timeout_evt pulses.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy,
  output logic                   timeout_evt
);

  localparam int unsigned W_IDX = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_GRANT = 4'b0010,
    S_START = 4'b0100,
    S_WAIT  = 4'b1000
  } state_t;

  state_t               r_state;
  logic [NUM_REQ-1:0]   r_grant;
  logic [W_IDX-1:0]     r_gidx;
  logic [W_IDX-1:0]     r_rr_ptr;
  logic                 r_last_q;
  logic                 r_tx_start;
  logic [7:0]           r_tx_data;

  logic                 w_win_found;
  logic [W_IDX-1:0]     w_win_idx;
  logic [W_IDX-1:0]     w_cand;
  logic                 w_sel_valid;
  logic                 w_sel_last;
  logic [7:0]           w_sel_data;
  logic                 w_hs;

  // The parameter only feeds the optional stall timer.
  wire w_unused_timeout = (TIMEOUT_CYCLES == 0);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned W_CNT = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [W_CNT-1:0]     r_cnt;
  logic                 r_timeout_evt;
  assign timeout_evt = r_timeout_evt;
`else
  assign timeout_evt = 1'b0;
`endif

  // Owner lane selection.
  assign w_sel_valid = req_valid[r_gidx];
  assign w_sel_last  = req_last[r_gidx];
  assign w_sel_data  = req_data[{r_gidx, 3'b000} +: 8];

  // Byte handshake with the current owner; ready is combinational.
  assign w_hs      = (r_state == S_GRANT) && w_sel_valid && !tx_busy;
  assign req_ready = w_hs ? r_grant : '0;

  assign grant    = r_grant;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;

  // Round-robin winner search starting one past the last owner.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = W_IDX'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (req_valid[w_cand]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_cand;
      end
    end
  end

  // Arbitration FSM with registered grant, start pulse and data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_gidx     <= '0;
      r_rr_ptr   <= W_IDX'(NUM_REQ - 1);
      r_last_q   <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
`ifdef UART_ARB_TIMEOUT_EN
      r_cnt         <= '0;
      r_timeout_evt <= 1'b0;
`endif
    end else begin
      r_tx_start <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      r_timeout_evt <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          r_grant <= '0;
          if (w_win_found) begin
            r_grant <= NUM_REQ'(1) << w_win_idx;
            r_gidx  <= w_win_idx;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_hs) begin
            r_tx_data  <= w_sel_data;
            r_last_q   <= w_sel_last;
            r_tx_start <= 1'b1;
            r_state    <= S_START;
`ifdef UART_ARB_TIMEOUT_EN
            r_cnt <= '0;
          end else if (!w_sel_valid) begin
            if (r_cnt == W_CNT'(TIMEOUT_CYCLES - 1)) begin
              r_cnt         <= '0;
              r_grant       <= '0;
              r_rr_ptr      <= r_gidx;
              r_timeout_evt <= 1'b1;
              r_state       <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + W_CNT'(1);
            end
`endif
          end
        end
        S_START: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (!tx_busy) begin
            if (r_last_q) begin
              r_rr_ptr <= r_gidx;
              r_grant  <= '0;
              r_state  <= S_IDLE;
            end else begin
              r_state <= S_GRANT;
            end
          end
        end
        default: begin
          r_grant <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple uart_basic
// busy model and per-lane byte queues.
module tb_uart_tx_arbiter;

  localparam int unsigned NREQ     = 4;
  localparam int unsigned BUSY_LEN = 6;

  logic              clk;
  logic              reset_n;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   grant;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic              timeout_evt;

  int n_chk = 0;
  int n_err = 0;

  logic [8:0] lane_q [NREQ][$];

  logic [7:0]      cap_data  [256];
  logic [NREQ-1:0] cap_grant [256];
  int cap_n    = 0;
  int viol_n   = 0;
  int tout_n   = 0;
  int bcnt     = 0;

  uart_tx_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .timeout_evt(timeout_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // uart_basic model: busy from the cycle after tx_start for BUSY_LEN cycles.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) bcnt <= 0;
    else if (tx_start) bcnt <= BUSY_LEN;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end
  assign tx_busy = (bcnt != 0);

  // Log every start pulse and watch protocol rules.
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      cap_data[cap_n[7:0]]  = tx_data;
      cap_grant[cap_n[7:0]] = grant;
      cap_n++;
    end
    if ((req_ready & ~grant) != '0) viol_n++;
    if ($countones(req_ready) > 1) viol_n++;
    if (timeout_evt === 1'b1) tout_n++;
  end

  // Lane drivers: pop a byte after its handshake edge, present the queue head.
  always begin
    logic [NREQ-1:0] hs;
    @(negedge clk);
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (hs[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
      if (lane_q[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = lane_q[i][0][7:0];
        req_last[i]        = lane_q[i][0][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input int lane, input logic [7:0] b, input logic last);
    lane_q[lane].push_back({last, b});
  endtask

  function automatic int q_total();
    int s = 0;
    for (int i = 0; i < NREQ; i++) s += lane_q[i].size();
    return s;
  endfunction

  // Wait until all queues drained and the UART released; bounded.
  task automatic wait_idle(input string tag, input int max_cyc);
    logic done = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      step();
      if (q_total() == 0 && grant == '0 && !tx_busy && req_valid == '0) begin
        done = 1'b1;
        break;
      end
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic chk_cap(input string tag, input int idx, input logic [7:0] d, input logic [NREQ-1:0] g);
    check({tag, "_data"},  32'(cap_data[idx[7:0]]),  32'(d));
    check({tag, "_grant"}, 32'(cap_grant[idx[7:0]]), 32'(g));
  endtask

  initial begin
    int base;
    logic seen;
    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;

    // Reset state.
    #3;
    check("rst_grant",    32'(grant),       32'h0);
    check("rst_ready",    32'(req_ready),   32'h0);
    check("rst_start",    32'(tx_start),    32'h0);
    check("rst_data",     32'(tx_data),     32'h0);
    check("rst_tout",     32'(timeout_evt), 32'h0);
    step(3);
    reset_n = 1'b1;

    // Idle with no requests.
    step(10);
    check("idle_grant",   32'(grant),   32'h0);
    check("idle_nostart", 32'(cap_n),   32'd0);
    check("idle_data",    32'(tx_data), 32'h0);

    // Requester 2: 3-byte packet, first-byte latency checked exactly.
    base = cap_n;
    push(2, 8'h48, 1'b0);
    push(2, 8'h69, 1'b0);
    push(2, 8'h0A, 1'b1);
    step();
    check("p2_valid_seen", 32'(req_valid), 32'h4);
    step();
    check("p2_grant_n1",  32'(grant),     32'h4);
    check("p2_ready_n1",  32'(req_ready), 32'h4);
    check("p2_start_n1",  32'(tx_start),  32'h0);
    step();
    check("p2_start_n2",  32'(tx_start),  32'h1);
    check("p2_data_n2",   32'(tx_data),   32'h48);
    step();
    check("p2_start_1w",  32'(tx_start),  32'h0);
    wait_idle("p2_done", 200);
    check("p2_count", 32'(cap_n - base), 32'd3);
    chk_cap("p2_b0", base + 0, 8'h48, 4'b0100);
    chk_cap("p2_b1", base + 1, 8'h69, 4'b0100);
    chk_cap("p2_b2", base + 2, 8'h0A, 4'b0100);
    check("p2_grant_rel", 32'(grant),   32'h0);
    check("p2_data_hold", 32'(tx_data), 32'h0A);

    // Requesters 0 and 1 from reset: order 0,1,0,1.
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    base = cap_n;
    push(0, 8'h11, 1'b1);
    push(1, 8'h22, 1'b1);
    push(0, 8'h33, 1'b1);
    push(1, 8'h44, 1'b1);
    wait_idle("rr_done", 400);
    check("rr_count", 32'(cap_n - base), 32'd4);
    chk_cap("rr_0", base + 0, 8'h11, 4'b0001);
    chk_cap("rr_1", base + 1, 8'h22, 4'b0010);
    chk_cap("rr_2", base + 2, 8'h33, 4'b0001);
    chk_cap("rr_3", base + 3, 8'h44, 4'b0010);

    // Requester 3 waits while requester 1 owns the UART.
    base = cap_n;
    push(1, 8'hA1, 1'b0);
    push(1, 8'hA2, 1'b0);
    push(1, 8'hA3, 1'b1);
    step(4);
    push(3, 8'hB1, 1'b1);
    step(3);
    check("hold_grant",  32'(grant),        32'h2);
    check("hold_valid3", 32'(req_valid[3]), 32'h1);
    check("hold_ready3", 32'(req_ready[3]), 32'h0);
    wait_idle("hold_done", 400);
    check("hold_count", 32'(cap_n - base), 32'd4);
    chk_cap("hold_0", base + 0, 8'hA1, 4'b0010);
    chk_cap("hold_1", base + 1, 8'hA2, 4'b0010);
    chk_cap("hold_2", base + 2, 8'hA3, 4'b0010);
    chk_cap("hold_3", base + 3, 8'hB1, 4'b1000);

    // Requester 1 stalls after a non-last byte.
    base = cap_n;
    push(1, 8'h55, 1'b0);
`ifdef UART_ARB_TIMEOUT_EN
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (timeout_evt) begin
        seen = 1'b1;
        break;
      end
    end
    check("to_seen", 32'(seen), 32'd1);
    step();
    check("to_pulse1", 32'(timeout_evt), 32'h0);
    check("to_grant",  32'(grant),       32'h0);
    check("to_count",  32'(tout_n),      32'd1);
    base = cap_n;
    push(1, 8'h77, 1'b1);
    push(2, 8'h66, 1'b1);
    wait_idle("to_done", 400);
    chk_cap("to_0", base + 0, 8'h66, 4'b0100);
    chk_cap("to_1", base + 1, 8'h77, 4'b0010);
`else
    step(40);
    check("stall_grant", 32'(grant),     32'h2);
    check("stall_ready", 32'(req_ready), 32'h0);
    check("stall_tout",  32'(tout_n),    32'd0);
    push(1, 8'h56, 1'b1);
    wait_idle("stall_done", 400);
    check("stall_count", 32'(cap_n - base), 32'd2);
    chk_cap("stall_0", base + 0, 8'h55, 4'b0010);
    chk_cap("stall_1", base + 1, 8'h56, 4'b0010);
`endif

    // Reset while waiting on the UART; requester 0 must win afterwards.
    push(2, 8'h99, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (tx_start) begin
        seen = 1'b1;
        break;
      end
    end
    check("rw_started", 32'(seen), 32'd1);
    step(2);
    check("rw_busy", 32'(tx_busy), 32'h1);
    reset_n = 1'b0;
    lane_q[2].delete();
    #1;
    check("rw_grant", 32'(grant),       32'h0);
    check("rw_ready", 32'(req_ready),   32'h0);
    check("rw_start", 32'(tx_start),    32'h0);
    check("rw_data",  32'(tx_data),     32'h0);
    check("rw_tout",  32'(timeout_evt), 32'h0);
    step(3);
    reset_n = 1'b1;
    base = cap_n;
    push(3, 8'hC3, 1'b1);
    push(0, 8'hC0, 1'b1);
    wait_idle("rw_done", 400);
    chk_cap("rw_0", base + 0, 8'hC0, 4'b0001);
    chk_cap("rw_1", base + 1, 8'hC3, 4'b1000);

    // Protocol monitor totals.
    check("ready_rules", 32'(viol_n), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
